sram_fill_verify: RTL
=====================

// Module: sram_fill_verify
// PURPOSE
//  Downstream consumer of the 16-bit test counter. On start, writes one counter word per
//  8-phase slot to sequential K6R4016V1D-TC10 SRAM addresses (FILL), then reads them back
//  (VERIFY) and checks each word against seed+address. Reports busy/done/pass/error count.
//  Sits between the test counter / clkPhase source and the top-level SRAM tristate pins.
// PARAMETERS
//  ADDR_W     18            SRAM word-address width (256K x16)
//  LAST_ADDR  2**ADDR_W-1   final address of fill/verify sweep; benches use small values
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  clkPhase     in   3       free-running slot phase 0..7
//  start        in   1       request a fill+verify run (level or pulse)
//  data_in      in   16      test counter; changes only on edge where clkPhase==5
//  sram_addr    out  ADDR_W  SRAM address
//  sram_dq_out  out  16      write data to pad
//  sram_dq_oe   out  1       1 = drive pad with sram_dq_out
//  sram_dq_in   in   16      read data from pad
//  sram_ce_n/sram_oe_n/sram_we_n  out 1 each  SRAM strobes, active low
//  sram_ub_n/sram_lb_n            out 1 each  byte enables; held 0 except in reset (1)
//  busy         out  1       run in progress (pending, FILL or VERIFY)
//  done         out  1       run finished; held until next accepted start
//  pass         out  1       valid with done; 1 = err_count==0
//  err_count    out  16      mismatches this run, saturates at 16'hFFFF
//  err_addr     out  ADDR_W  first failing address (see CONFIGURATION)
//  err_data     out  16      data read at first failing address
// BEHAVIOUR
//  - Reset (async): state IDLE; addr 0; dq_oe 0; ce_n/oe_n/we_n/ub_n/lb_n 1; busy/done/pass 0;
//    err_count/err_addr/err_data 0. All outputs registered.
//  - States IDLE, PEND, FILL, VERIFY, DONE. IDLE/DONE + start -> PEND (busy=1, done=pass=0,
//    err_count cleared). start in PEND/FILL/VERIFY ignored.
//  - PEND -> FILL on edge with clkPhase==0: addr=0, seed=data_in captured.
//  - Write slot (edges by sampled clkPhase): 0: addr, dq_out=data_in, dq_oe=1, ce_n=0;
//    1: we_n=0; 5: we_n=1 (low exactly 4 clk); 6: dq_oe=0, ce_n=1; 7: addr advance.
//  - FILL slot at LAST_ADDR, phase 7 -> VERIFY, addr=0.
//  - Read slot: 0: addr, ce_n=0, oe_n=0; 5: sample sram_dq_in; 6: oe_n=ce_n=1, compare with
//    expected = seed + addr[15:0] (mod 2^16, wraps 16'hFFFF->0); on mismatch err_count+1 (sat).
//  - VERIFY slot at LAST_ADDR, phase 7 -> DONE: busy=0, done=1, pass=(err_count==0).
//  - Address wraps only via LAST_ADDR terminal compare; never exceeds LAST_ADDR.
//  - Run length from FILL entry to done: 16*(LAST_ADDR+1) clk.
//  - Reset mid-run: strobes deasserted and dq released immediately (async); no partial report.
// CONFIGURATION
//  ERROR_CAPTURE_EN defined: on first mismatch of a run latch err_addr=addr,
//    err_data=sampled word; later mismatches do not overwrite; cleared on accepted start.
//  Not defined: err_addr/err_data ports exist, tied to 0; no capture registers.
// STRUCTURE
//  sramfb_pkg: state enum; phase constants PH_ADDR=0, PH_WE_ON=1, PH_WE_OFF=5,
//    PH_SAMPLE=5, PH_RELEASE=6, PH_ADV=7; DATA_W=16.
//  Sub-module sram_slot_strobes: given clkPhase + mode (idle/write/read) produces registered
//    ce_n/oe_n/we_n/dq_oe; parent owns FSM, address, seed, compare, reporting.
// TESTING (bench: testgen-equivalent counter, behavioural SRAM model, LAST_ADDR=7)
//  1 Reset asserted mid-idle -> all strobes 1, dq_oe 0, busy/done/pass 0, err_count 0.
//  2 start, seed 16'h0010 -> model holds 0x0010..0x0017 at addr 0..7; each we_n low 4 clk.
//  3 Clean run -> done=1, pass=1, err_count=0, 128 clk after FILL entry; start while busy ignored.
//  4 Model flips bit0 at addr 3 after FILL -> err_count=1, pass=0; with ERROR_CAPTURE_EN
//    err_addr=3, err_data=0x0012.
//  5 Seed 16'hFFFE -> expected wraps (FFFE,FFFF,0000..0005); pass=1.
//  6 reset_n low during FILL addr 4 -> strobes high same cycle; new start runs clean, pass=1.

Source files
------------

// File: rtl/sramfb_pkg.sv
// Shared types and slot-phase constants for the SRAM fill/verify engine.
package sramfb_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] PH_ADDR    = 3'd0;
    localparam logic [2:0] PH_WE_ON   = 3'd1;
    localparam logic [2:0] PH_WE_OFF  = 3'd5;
    localparam logic [2:0] PH_SAMPLE  = 3'd5;
    localparam logic [2:0] PH_RELEASE = 3'd6;
    localparam logic [2:0] PH_ADV     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_FILL,
        ST_VERIFY,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_WRITE,
        MODE_READ
    } slot_mode_t;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sram_slot_strobes.sv
// Registered SRAM strobes for one 8-phase slot; the parent selects write, read or idle.
module sram_slot_strobes
    import sramfb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] phase,
    input  slot_mode_t mode,
    output logic       ce_n,
    output logic       oe_n,
    output logic       we_n,
    output logic       dq_oe
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ce_n  <= 1'b1;
            oe_n  <= 1'b1;
            we_n  <= 1'b1;
            dq_oe <= 1'b0;
        end else begin
            case (mode)
                MODE_WRITE: begin
                    oe_n <= 1'b1;
                    case (phase)
                        PH_ADDR:    begin ce_n <= 1'b0; dq_oe <= 1'b1; end
                        PH_WE_ON:   we_n <= 1'b0;
                        PH_WE_OFF:  we_n <= 1'b1;
                        PH_RELEASE: begin ce_n <= 1'b1; dq_oe <= 1'b0; end
                        default:    ;
                    endcase
                end
                MODE_READ: begin
                    we_n  <= 1'b1;
                    dq_oe <= 1'b0;
                    case (phase)
                        PH_ADDR:    begin ce_n <= 1'b0; oe_n <= 1'b0; end
                        PH_RELEASE: begin ce_n <= 1'b1; oe_n <= 1'b1; end
                        default:    ;
                    endcase
                end
                default: begin
                    ce_n  <= 1'b1;
                    oe_n  <= 1'b1;
                    we_n  <= 1'b1;
                    dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_fill_verify.sv
// Fills SRAM with the test counter, one word per 8-phase slot, then reads back and checks seed+addr.
// Optional first-error capture of err_addr/err_data is enabled by defining ERROR_CAPTURE_EN.
module sram_fill_verify
    import sramfb_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        clkPhase,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);

    state_t            state_reg, state_next;
    slot_mode_t        slot_mode;
    logic [DATA_W-1:0] seed_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] expected_word;
    logic              at_last;
    logic              accept_start;
    logic              mismatch;

    assign at_last       = (sram_addr == LAST_ADDR);
    assign accept_start  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign expected_word = seed_reg + DATA_W'(sram_addr);
    assign mismatch      = (rd_data_reg != expected_word);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // PEND joins FILL on the phase-0 edge, so that edge already opens the first write slot.
    always_comb begin
        state_next = state_reg;
        slot_mode  = MODE_IDLE;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start) state_next = ST_PEND;
            ST_PEND: begin
                if (clkPhase == PH_ADDR) begin
                    state_next = ST_FILL;
                    slot_mode  = MODE_WRITE;
                end
            end
            ST_FILL: begin
                slot_mode = MODE_WRITE;
                if (clkPhase == PH_ADV && at_last) state_next = ST_VERIFY;
            end
            ST_VERIFY: begin
                slot_mode = MODE_READ;
                if (clkPhase == PH_ADV && at_last) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    sram_slot_strobes u_strobes (
        .clk     (clk),
        .reset_n (reset_n),
        .phase   (clkPhase),
        .mode    (slot_mode),
        .ce_n    (sram_ce_n),
        .oe_n    (sram_oe_n),
        .we_n    (sram_we_n),
        .dq_oe   (sram_dq_oe)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            seed_reg    <= '0;
            rd_data_reg <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
        end else begin
            sram_ub_n <= 1'b0;
            sram_lb_n <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                    end
                end
                ST_PEND: begin
                    if (clkPhase == PH_ADDR) begin
                        sram_addr   <= '0;
                        seed_reg    <= data_in;
                        sram_dq_out <= data_in;
                    end
                end
                ST_FILL: begin
                    if (clkPhase == PH_ADDR) sram_dq_out <= data_in;
                    if (clkPhase == PH_ADV)  sram_addr   <= at_last ? '0 : sram_addr + 1'b1;
                end
                ST_VERIFY: begin
                    if (clkPhase == PH_SAMPLE) rd_data_reg <= sram_dq_in;
                    if (clkPhase == PH_RELEASE && mismatch) err_count <= sat_inc(err_count);
                    if (clkPhase == PH_ADV) begin
                        if (at_last) begin
                            sram_addr <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_count == '0);
                        end else begin
                            sram_addr <= sram_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ERROR_CAPTURE_EN
    logic [ADDR_W-1:0] err_addr_reg;
    logic [DATA_W-1:0] err_data_reg;

    // err_count is still zero on the first mismatch of a run, which marks it as the one to keep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_addr_reg <= '0;
            err_data_reg <= '0;
        end else if (accept_start) begin
            err_addr_reg <= '0;
            err_data_reg <= '0;
        end else if (state_reg == ST_VERIFY && clkPhase == PH_RELEASE && mismatch
                     && err_count == '0) begin
            err_addr_reg <= sram_addr;
            err_data_reg <= rd_data_reg;
        end
    end

    assign err_addr = err_addr_reg;
    assign err_data = err_data_reg;
`else
    logic unused_capture;
    assign unused_capture = accept_start;
    assign err_addr = '0;
    assign err_data = '0;
`endif

endmodule
